// File: rtl/div_result_bcd_pkg.sv
// Shared types and defaults for the divider result BCD converter.
package div_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int DIGITS_DEF = 10;
  localparam int CNT_W_DEF  = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef logic [4*DIGITS_DEF-1:0] bcd_t;

endpackage

// File: rtl/div_result_bcd_dabble.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift in a bit.
module bcd_dabble_step
  import div_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic                msb_i,
  output logic [4*DIGITS-1:0] bcd_o
);

  logic [4*DIGITS-1:0] adj;

  // Per-digit correction so the following shift carries correctly into the next digit
  always_comb begin
    adj = bcd_i;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_i[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = bcd_i[4*d +: 4] + 4'd3;
      end
    end
  end

  assign bcd_o = {adj[4*DIGITS-2:0], msb_i};

endmodule

// File: rtl/div_result_bcd.sv
// Converts a signed quotient and unsigned remainder to packed BCD, one bit per
// cycle for both operands in lockstep, and holds the result for a consumer.
module div_result_bcd
  import div_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                VALID,
  output logic                READY,
  input  logic [WIDTH-1:0]    Q,
  input  logic [WIDTH-2:0]    R,
  input  logic                div_zero_err,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                Q_NEG,
  output logic [4*DIGITS-1:0] Q_BCD,
  output logic [4*DIGITS-1:0] R_BCD,
  output logic                err
);

  localparam int CNT_W = $clog2(WIDTH);

  // Two's-complement magnitude as an unsigned value; the most negative input
  // maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    magnitude = v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]    qbin_q, rbin_q;
  logic [4*DIGITS-1:0] qacc_q, racc_q;
  logic [4*DIGITS-1:0] qacc_nxt, racc_nxt;
  logic                neg_q;

  logic [4*DIGITS-1:0] q_bcd_q, r_bcd_q;
  logic                q_neg_q, err_q;

  logic                accept;
  logic                last_step;

  assign accept    = (state_q == IDLE) && VALID;
  assign last_step = (state_q == CONVERT) && (cnt_q == CNT_W'(WIDTH-1));

  bcd_dabble_step #(.DIGITS(DIGITS)) u_q_step (
    .bcd_i (qacc_q),
    .msb_i (qbin_q[WIDTH-1]),
    .bcd_o (qacc_nxt)
  );

  bcd_dabble_step #(.DIGITS(DIGITS)) u_r_step (
    .bcd_i (racc_q),
    .msb_i (rbin_q[WIDTH-1]),
    .bcd_o (racc_nxt)
  );

  // State and bit counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (VALID) begin
          state_d = div_zero_err ? DONE : CONVERT;
          cnt_d   = '0;
        end
      end
      CONVERT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    READY     = (state_q == IDLE);
    OUT_VALID = (state_q == DONE);
  end

  // Working shift registers: loaded on accept, advanced one bit per CONVERT cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      qbin_q <= magnitude(Q);
      rbin_q <= {1'b0, R};
      qacc_q <= '0;
      racc_q <= '0;
      neg_q  <= Q[WIDTH-1];
    end else if (state_q == CONVERT) begin
      qbin_q <= {qbin_q[WIDTH-2:0], 1'b0};
      rbin_q <= {rbin_q[WIDTH-2:0], 1'b0};
      qacc_q <= qacc_nxt;
      racc_q <= racc_nxt;
    end
  end

  // Result registers: updated only on entry to DONE, held otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_bcd_q <= '0;
      r_bcd_q <= '0;
      q_neg_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept && div_zero_err) begin
      q_bcd_q <= '0;
      r_bcd_q <= '0;
      q_neg_q <= 1'b0;
      err_q   <= 1'b1;
    end else if (last_step) begin
      q_bcd_q <= qacc_nxt;
      r_bcd_q <= racc_nxt;
      q_neg_q <= neg_q;
      err_q   <= 1'b0;
    end
  end

  assign Q_BCD = q_bcd_q;
  assign R_BCD = r_bcd_q;
  assign Q_NEG = q_neg_q;
  assign err   = err_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd with hand-computed decimal expectations.
module tb_div_result_bcd;
  import div_pkg::*;

  logic        clk;
  logic        reset;
  logic        VALID;
  logic        READY;
  logic [31:0] Q;
  logic [30:0] R;
  logic        div_zero_err;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        Q_NEG;
  bcd_t        Q_BCD;
  bcd_t        R_BCD;
  logic        err;

  int n_vec  = 0;
  int n_miss = 0;
  int lat;

  div_result_bcd dut (
    .clk          (clk),
    .reset        (reset),
    .VALID        (VALID),
    .READY        (READY),
    .Q            (Q),
    .R            (R),
    .div_zero_err (div_zero_err),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .Q_NEG        (Q_NEG),
    .Q_BCD        (Q_BCD),
    .R_BCD        (R_BCD),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one result and hold VALID until the accepting edge.
  task automatic accept(input logic [31:0] q, input logic [30:0] r, input logic dz);
    int n;
    n = 0;
    while (!READY && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!READY) chk("ready_timeout", 64'(READY), 64'd1);
    Q = q; R = r; div_zero_err = dz; VALID = 1'b1;
    @(posedge clk); #1;
    VALID = 1'b0;
  endtask

  // Count edges after the accepting edge until OUT_VALID is seen.
  task automatic wait_out(output int n);
    n = 0;
    while (!OUT_VALID && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!OUT_VALID) chk("out_timeout", 64'(OUT_VALID), 64'd1);
  endtask

  task automatic consume();
    OUT_READY = 1'b1;
    @(posedge clk); #1;
    OUT_READY = 1'b0;
    chk("consume_ov", 64'(OUT_VALID), 64'd0);
    chk("consume_rdy", 64'(READY), 64'd1);
  endtask

  task automatic chk_res(input string tag, input logic neg, input logic [39:0] qb,
                         input logic [39:0] rb, input logic e);
    chk({tag, "_neg"}, 64'(Q_NEG), 64'(neg));
    chk({tag, "_qbcd"}, 64'(Q_BCD), 64'(qb));
    chk({tag, "_rbcd"}, 64'(R_BCD), 64'(rb));
    chk({tag, "_err"}, 64'(err), 64'(e));
  endtask

  initial begin
    reset = 1'b0; VALID = 1'b0; Q = '0; R = '0; div_zero_err = 1'b0; OUT_READY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_res("rst", 1'b0, 40'h0, 40'h0, 1'b0);
    chk("rst_ov", 64'(OUT_VALID), 64'd0);
    chk("rst_rdy", 64'(READY), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: small positive quotient, latency check
    accept(32'd25, 31'd0, 1'b0);
    wait_out(lat);
    chk("t1_lat", 64'(lat), 64'd32);
    chk_res("t1", 1'b0, 40'h0000000025, 40'h0, 1'b0);
    consume();

    // 2: negative quotient
    accept(32'hFFFFFFFA, 31'd3, 1'b0);
    wait_out(lat);
    chk_res("t2", 1'b1, 40'h0000000006, 40'h0000000003, 1'b0);
    consume();

    // 3: most negative quotient, largest remainder
    accept(32'h80000000, 31'h7FFFFFFF, 1'b0);
    wait_out(lat);
    chk("t3_lat", 64'(lat), 64'd32);
    chk_res("t3", 1'b1, 40'h2147483648, 40'h2147483647, 1'b0);
    consume();

    // 4: divide by zero is visible right after the accepting edge
    accept(32'd0, 31'd0, 1'b1);
    wait_out(lat);
    chk("t4_lat", 64'(lat), 64'd0);
    chk_res("t4", 1'b0, 40'h0, 40'h0, 1'b1);
    consume();
    chk_res("t4_hold", 1'b0, 40'h0, 40'h0, 1'b1);

    // 5: backpressure with VALID held high and new operands waiting
    accept(32'h0065CBD8, 31'd1, 1'b0);
    wait_out(lat);
    Q = 32'hFFFFFF85; R = 31'd45; div_zero_err = 1'b0; VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t5_ov", 64'(OUT_VALID), 64'd1);
      chk("t5_rdy", 64'(READY), 64'd0);
      chk_res("t5", 1'b0, 40'h0006671320, 40'h0000000001, 1'b0);
    end
    OUT_READY = 1'b1;
    @(posedge clk); #1;
    OUT_READY = 1'b0;
    chk("t5_idle_rdy", 64'(READY), 64'd1);
    chk("t5_idle_ov", 64'(OUT_VALID), 64'd0);
    chk_res("t5_idle", 1'b0, 40'h0006671320, 40'h0000000001, 1'b0);
    @(posedge clk); #1;
    VALID = 1'b0;
    chk("t5_cap_rdy", 64'(READY), 64'd0);
    wait_out(lat);
    chk("t5b_lat", 64'(lat), 64'd32);
    chk_res("t5b", 1'b1, 40'h0000000123, 40'h0000000045, 1'b0);
    consume();

    // 6: asynchronous reset in the middle of a conversion
    accept(32'd999, 31'd5, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_ov", 64'(OUT_VALID), 64'd0);
    chk("t6_rdy", 64'(READY), 64'd1);
    chk_res("t6_rst", 1'b0, 40'h0, 40'h0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_rel_rdy", 64'(READY), 64'd1);
    OUT_READY = 1'b1;
    accept(32'd27, 31'd0, 1'b0);
    wait_out(lat);
    chk("t6_lat", 64'(lat), 64'd32);
    chk_res("t6", 1'b0, 40'h0000000027, 40'h0, 1'b0);
    @(posedge clk); #1;
    chk("t6_one_cycle", 64'(OUT_VALID), 64'd0);
    OUT_READY = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/div_result_bcd.md
# div_result_bcd

Downstream stage of the signed remainder long divider. It takes one completed result per handshake: a signed quotient, a non-negative remainder and the divide-by-zero flag. It converts the quotient magnitude and the remainder to packed BCD with an iterative double-dabble, one bit per cycle for both operands in lockstep, and holds the decimal result for a display or UART formatter until that consumer acknowledges it.

## Interface
- WIDTH, 32: quotient width; remainder width is WIDTH-1.
- DIGITS, 10: BCD digits per operand; must cover 2^(WIDTH-1).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- VALID  in  1  divider result valid.
- READY  out  1  block idle and able to accept.
- Q  in  WIDTH  two's-complement quotient.
- R  in  WIDTH-1  unsigned remainder.
- div_zero_err  in  1  divider flagged division by zero.
- OUT_VALID  out  1  decimal result available.
- OUT_READY  in  1  consumer accepts the result.
- Q_NEG  out  1  quotient sign.
- Q_BCD  out  4*DIGITS  quotient magnitude, packed BCD, most-significant digit in the top nibble.
- R_BCD  out  4*DIGITS  remainder, packed BCD, same packing.
- err  out  1  result is a divide-by-zero.

## Operation
- **States:** IDLE, CONVERT, DONE.
- **IDLE:**
  - READY=1.
  - On VALID&&READY, capture the inputs.
  - If div_zero_err=1, go directly to DONE with Q_BCD=R_BCD=0, Q_NEG=0, err=1.
  - Otherwise load the internal shift registers:
    - magnitude = Q[WIDTH-1] ? (~Q+1) : Q, taken as an unsigned WIDTH-bit value, so 0x80000000 yields 2147483648;
    - R zero-extended to WIDTH bits;
    - BCD accumulators cleared;
    - bit counter = 0;
    - latch Q_NEG = Q[WIDTH-1].
  - Go to CONVERT.
- **CONVERT:** READY=0. Each cycle, for each operand:
  - add 3 to every BCD digit that is ≥5;
  - then shift {bcd, bin} left by one.
  - The counter increments. When the counter reaches WIDTH-1, this cycle's step is the last one: register the BCD results into Q_BCD/R_BCD, set err=0 and go to DONE.
- **DONE:**
  - OUT_VALID=1 and READY=0.
  - All outputs stay stable until OUT_READY=1.
  - On OUT_READY=1, return to IDLE. OUT_VALID drops on the next cycle.
- **Output persistence:** Q_BCD, R_BCD, Q_NEG and err change only on entry to DONE. They keep their value in IDLE until the next result.
- **Zero quotient:** Q=0 gives Q_NEG=0 and Q_BCD=0. Negative zero cannot occur.

## Timing
- **Reset values:** OUT_VALID=0, Q_BCD=0, R_BCD=0, Q_NEG=0, err=0, state IDLE, so READY=1.
- **Latency, normal:** OUT_VALID rises exactly WIDTH (32) cycles after the accepting edge.
- **Latency, div_zero_err:** 1 cycle.
- **No skid buffer:**
  - VALID in CONVERT or DONE is ignored, and the upstream holds it.
  - The DONE→IDLE transition costs one cycle before READY=1.
  - Minimum initiation interval is WIDTH+2 cycles.
- **Backpressure:** OUT_READY may already be high when DONE is entered. The result is then consumed on the first DONE cycle, and OUT_VALID is high for exactly one cycle.
- **Reset mid-operation:** reset low at any time immediately clears state, counter and all outputs, and the conversion in progress is discarded. After release the block is in IDLE with READY=1.
- **Simultaneous events:** VALID in the same cycle as a DONE→IDLE handshake is not accepted until the following cycle.

## Structure
- **Package div_pkg:**
  - WIDTH and DIGITS defaults;
  - state enum {IDLE, CONVERT, DONE};
  - bcd_t typedef (logic [4*DIGITS-1:0]);
  - counter width $clog2(WIDTH).
- **Sub-module bcd_dabble_step:** combinational. Inputs are a BCD vector and the incoming MSB; the output is the add-3-then-shift result. The top level instantiates it twice, once for Q and once for R.
- **Top level:** FSM, counter, operand shift registers, output registers.

## Test plan
1. Q=25, R=0, div_zero_err=0 → Q_NEG=0, Q_BCD=40'h0000000025, R_BCD=0, err=0. OUT_VALID exactly 32 cycles after accept.
2. Q=32'hFFFFFFFA (-6), R=3 → Q_NEG=1, Q_BCD=40'h0000000006, R_BCD=40'h0000000003.
3. Q=32'h80000000, R=31'h7FFFFFFF → Q_NEG=1, Q_BCD=40'h2147483648, R_BCD=40'h2147483647.
4. div_zero_err=1 with Q=R=0 → err=1, Q_BCD=R_BCD=0, OUT_VALID one cycle after accept.
5. Q=32'h65CBD8, R=1; hold OUT_READY low for 10 cycles in DONE while VALID is kept high with new operands → outputs stable at 40'h0006671320 / 40'h0000000001, READY=0, no second capture. After OUT_READY pulses, READY=1 one cycle later.
6. Assert reset at cycle 10 of CONVERT → OUT_VALID and all outputs 0 immediately, READY=1 after release. Then Q=32'd27, R=0 converts to Q_BCD=40'h0000000027 with normal latency.
